tinker_control_unit: RTL and testbench
======================================

Name: tinker_control_unit

Overview:
Multi-cycle sequencer for the tinker core. Drives instruction fetch, latches the instruction register, and steps each instruction through decode/execute/memory/writeback using the opcode and literal from instruction_decoder. Issues handshakes to instruction memory, data memory and the multi-cycle FPU. Raises halt and illegal-instruction status to the top level.

Parameters:
TIMEOUT, 64, max cycles waiting on any ack or done before entering ERROR
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
opcode  input  5  from instruction_decoder
literal  input  12  from instruction_decoder
branch_taken  input  1  datapath branch condition, valid in EXECUTE
imem_ack  input  1  instruction word valid this cycle
dmem_ack  input  1  data access complete this cycle
fpu_done  input  1  FPU result valid this cycle
imem_req  output  1  fetch request, held until ack
ir_load  output  1  latch instruction register
dmem_req  output  1  data request, held until ack
dmem_we  output  1  data write (store/call)
fpu_start  output  1  one-cycle FPU launch pulse
pc_inc  output  1  PC <= PC+4
pc_we_target  output  1  PC <= branch/return target
rf_we  output  1  register-file write strobe
halted  output  1  sticky halt
illegal  output  1  sticky illegal-opcode flag
error  output  1  sticky timeout flag
retired  output  CNT_W  completed instruction count

Behaviour:
- Reset: state FETCH; all outputs 0; retired 0; wait counter 0. Reset in any state, including mid-handshake, aborts the handshake with no further req.
- States: FETCH, DECODE, EXECUTE, FPU_WAIT, MEM, WRITEBACK, HALT, TRAP, ERROR.
- FETCH: imem_req=1. On imem_ack: ir_load=1 in the same cycle, next DECODE.
- DECODE: classify opcode. 0x1e/0x1f, or 0x0f with literal!=0 -> TRAP. 0x0f with literal==0 -> HALT. Otherwise -> EXECUTE.
- EXECUTE:
  - ALU ops (0x00-0x07, 0x11, 0x12, 0x18-0x1d) -> WRITEBACK.
  - FPU (0x14-0x17): fpu_start=1 for one cycle -> FPU_WAIT.
  - Load (0x10), return (0x0d), store (0x13), call (0x0c) -> MEM.
  - Branch (0x08-0x0b, 0x0e): pc_we_target=branch_taken, pc_inc=!branch_taken; retire; -> FETCH.
- FPU_WAIT: on fpu_done -> WRITEBACK.
- MEM: dmem_req=1; dmem_we=1 for 0x13 and 0x0c. On dmem_ack:
  - 0x10 -> WRITEBACK.
  - 0x13: pc_inc, retire -> FETCH.
  - 0x0c and 0x0d: pc_we_target, retire -> FETCH.
- WRITEBACK: rf_we=1, pc_inc=1, retire, -> FETCH. Single cycle.
- Latency with zero-wait acks: ALU 4 cycles, load 5, store/call/return 4, branch 3, FPU 5+fpu latency.
- Wait counter: clears on entry to FETCH/FPU_WAIT/MEM. Increments each cycle the awaited ack/done is low. When it reaches TIMEOUT without ack -> ERROR. An ack arriving on the TIMEOUT cycle itself wins.
- HALT/TRAP/ERROR are terminal until reset, with all strobes 0.
  - HALT: halted=1, and the halt instruction is counted in retired.
  - TRAP: illegal=1. ERROR: error=1. Neither increments retired.
- Exactly one of pc_inc/pc_we_target is asserted per retired instruction. rf_we is never asserted outside WRITEBACK.
- retired wraps modulo 2^CNT_W.
- Spurious acks are ignored: imem_ack outside FETCH, dmem_ack outside MEM, fpu_done outside FPU_WAIT.

Decomposition:
- Package tinker_ctrl_pkg holds:
  - state enum.
  - opcode localparams (OP_ADD=5'h18, OP_ADDI=5'h19, OP_PRIV=5'h0f, etc.).
  - instr_class enum (ALU, FPU, LOAD, STORE, CALL, RET, BRANCH, HALT, ILLEGAL).
  - function classify(opcode, literal).
- One sub-module, tinker_wait_timer: wait counter plus timeout compare, reused for all three handshakes.

Test Plan:
1. Reset, then ADD (0x18) with imem_ack/fpu-free zero-wait -> rf_we and pc_inc pulse in cycle 4; retired=1; back in FETCH cycle 5.
2. Load 0x10 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, rf_we one cycle after ack; store 0x13 -> dmem_we=1, no rf_we.
3. Branch 0x0b with branch_taken=1 then 0 -> pc_we_target then pc_inc in EXECUTE; 3 cycles each; retired +2.
4. DIVF 0x17 with fpu_done after 10 cycles -> single fpu_start pulse, rf_we 1 cycle after done; spurious fpu_done during FETCH has no effect.
5. Opcode 0x0f literal 0 -> halted=1 sticky, retired incremented; opcode 0x1f -> illegal=1, retired unchanged; reset clears both.
6. imem_ack never arrives -> error=1 after 64 cycles; ack on cycle 64 instead -> normal DECODE; reset asserted mid-MEM -> dmem_req 0 next cycle, state FETCH.

Source files
------------

// File: rtl/tinker_ctrl_pkg.sv
// Shared types, opcode map and instruction classifier for the tinker control unit.
package tinker_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecute,
        StFpuWait,
        StMem,
        StWriteback,
        StHalt,
        StTrap,
        StError
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu,
        ClsFpu,
        ClsLoad,
        ClsStore,
        ClsCall,
        ClsRet,
        ClsBranch,
        ClsHalt,
        ClsIllegal
    } instr_class_e;

    localparam logic [4:0] OP_AND    = 5'h00;
    localparam logic [4:0] OP_SHFTLI = 5'h07;
    localparam logic [4:0] OP_BR     = 5'h08;
    localparam logic [4:0] OP_BRNZ   = 5'h0b;
    localparam logic [4:0] OP_CALL   = 5'h0c;
    localparam logic [4:0] OP_RETURN = 5'h0d;
    localparam logic [4:0] OP_BRGT   = 5'h0e;
    localparam logic [4:0] OP_PRIV   = 5'h0f;
    localparam logic [4:0] OP_LOAD   = 5'h10;
    localparam logic [4:0] OP_MOV_RR = 5'h11;
    localparam logic [4:0] OP_MOV_RL = 5'h12;
    localparam logic [4:0] OP_STORE  = 5'h13;
    localparam logic [4:0] OP_ADDF   = 5'h14;
    localparam logic [4:0] OP_DIVF   = 5'h17;
    localparam logic [4:0] OP_ADD    = 5'h18;
    localparam logic [4:0] OP_ADDI   = 5'h19;
    localparam logic [4:0] OP_DIV    = 5'h1d;

    // Map an opcode/literal pair onto the sequencing class the FSM walks.
    function automatic instr_class_e classify(input logic [4:0] opcode, input logic [11:0] literal);
        instr_class_e cls;
        if (opcode == OP_PRIV) begin
            // Only priv with a zero literal (halt) is implemented.
            cls = (literal == '0) ? ClsHalt : ClsIllegal;
        end else if (opcode inside {[OP_AND:OP_SHFTLI], OP_MOV_RR, OP_MOV_RL, [OP_ADD:OP_DIV]}) begin
            cls = ClsAlu;
        end else if (opcode inside {[OP_ADDF:OP_DIVF]}) begin
            cls = ClsFpu;
        end else if (opcode inside {[OP_BR:OP_BRNZ], OP_BRGT}) begin
            cls = ClsBranch;
        end else if (opcode == OP_LOAD) begin
            cls = ClsLoad;
        end else if (opcode == OP_STORE) begin
            cls = ClsStore;
        end else if (opcode == OP_CALL) begin
            cls = ClsCall;
        end else if (opcode == OP_RETURN) begin
            cls = ClsRet;
        end else begin
            cls = ClsIllegal;
        end
        return cls;
    endfunction

endpackage

// File: rtl/tinker_wait_timer.sv
// Handshake wait counter: counts consecutive cycles spent waiting and flags the last allowed one.
module tinker_wait_timer
    import tinker_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Any non-waiting cycle (including the ack cycle) zeroes the count, so each wait starts fresh.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + W'(1);
        end
    end

    // Asserted on the TIMEOUT-th waiting cycle; an ack in that same cycle drops run and wins.
    assign expired = run && (count_q == LAST);

endmodule

// File: rtl/tinker_control_unit.sv
// Multi-cycle sequencer: fetch, decode, execute, FPU wait, memory and writeback for the tinker core.
module tinker_control_unit
    import tinker_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic [11:0]      literal,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             fpu_done,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             fpu_start,
    output logic             pc_inc,
    output logic             pc_we_target,
    output logic             rf_we,
    output logic             halted,
    output logic             illegal,
    output logic             error,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q;
    instr_class_e     cls_q;
    instr_class_e     dec_cls;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             wait_run;
    logic             wait_expired;

    assign dec_cls = classify(opcode, literal);
    assign retired = retired_q;

    // Waiting means sitting in a handshake state whose own ack/done is low this cycle.
    always_comb begin
        wait_run = ((state_q == StFetch)   && !imem_ack) ||
                   ((state_q == StFpuWait) && !fpu_done) ||
                   ((state_q == StMem)     && !dmem_ack);
    end

    tinker_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (wait_run),
        .expired(wait_expired)
    );

    // Strobes decoded from the registered state; all held low while reset is asserted.
    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        fpu_start    = 1'b0;
        pc_inc       = 1'b0;
        pc_we_target = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        error        = 1'b0;
        retire       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                StDecode: begin
                    // Halt retires here so it still gets its single PC update before freezing.
                    if (dec_cls == ClsHalt) begin
                        pc_inc = 1'b1;
                        retire = 1'b1;
                    end
                end
                StExecute: begin
                    fpu_start = (cls_q == ClsFpu);
                    if (cls_q == ClsBranch) begin
                        pc_we_target = branch_taken;
                        pc_inc       = !branch_taken;
                        retire       = 1'b1;
                    end
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q inside {ClsStore, ClsCall});
                    if (dmem_ack) begin
                        pc_inc       = (cls_q == ClsStore);
                        pc_we_target = (cls_q inside {ClsCall, ClsRet});
                        retire       = (cls_q != ClsLoad);
                    end
                end
                StWriteback: begin
                    rf_we  = 1'b1;
                    pc_inc = 1'b1;
                    retire = 1'b1;
                end
                StHalt:  halted  = 1'b1;
                StTrap:  illegal = 1'b1;
                StError: error   = 1'b1;
                default: ;
            endcase
        end
    end

    // Sequencer state, latched instruction class and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsAlu;
            retired_q <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        state_q <= StDecode;
                    end else if (wait_expired) begin
                        state_q <= StError;
                    end
                end
                StDecode: begin
                    cls_q <= dec_cls;
                    case (dec_cls)
                        ClsHalt:    state_q <= StHalt;
                        ClsIllegal: state_q <= StTrap;
                        default:    state_q <= StExecute;
                    endcase
                end
                StExecute: begin
                    case (cls_q)
                        ClsAlu:    state_q <= StWriteback;
                        ClsFpu:    state_q <= StFpuWait;
                        ClsBranch: state_q <= StFetch;
                        default:   state_q <= StMem;
                    endcase
                end
                StFpuWait: begin
                    if (fpu_done) begin
                        state_q <= StWriteback;
                    end else if (wait_expired) begin
                        state_q <= StError;
                    end
                end
                StMem: begin
                    if (dmem_ack) begin
                        state_q <= (cls_q == ClsLoad) ? StWriteback : StFetch;
                    end else if (wait_expired) begin
                        state_q <= StError;
                    end
                end
                StWriteback: state_q <= StFetch;
                StHalt, StTrap, StError: ;
                default: state_q <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_control_unit.sv
// Scoreboard bench for tinker_control_unit: directed instructions with hand-computed timing.
module tb_tinker_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic [11:0] literal;
    logic        branch_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        fpu_done;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        fpu_start;
    logic        pc_inc;
    logic        pc_we_target;
    logic        rf_we;
    logic        halted;
    logic        illegal;
    logic        error;
    logic [31:0] retired;

    tinker_control_unit #(
        .TIMEOUT(64),
        .CNT_W  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .literal     (literal),
        .branch_taken(branch_taken),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .fpu_done    (fpu_done),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .fpu_start   (fpu_start),
        .pc_inc      (pc_inc),
        .pc_we_target(pc_we_target),
        .rf_we       (rf_we),
        .halted      (halted),
        .illegal     (illegal),
        .error       (error),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // One expected retirement: cycle, PC strobe, retired count before it, strobe counts since last one.
    typedef struct {
        int cyc;
        int inc;
        int tgt;
        int rf;
        int ret;
        int n_ireq;
        int n_ir;
        int n_dreq;
        int n_dwe;
        int n_fst;
    } exp_t;

    exp_t sb[$];
    int   exp_retired = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: accumulate strobes and compare against the scoreboard at every PC update.
    int   m_ireq, m_ir, m_dreq, m_dwe, m_fst, m_rf;
    exp_t e;
    initial begin
        m_ireq = 0; m_ir = 0; m_dreq = 0; m_dwe = 0; m_fst = 0; m_rf = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_ireq = 0; m_ir = 0; m_dreq = 0; m_dwe = 0; m_fst = 0; m_rf = 0;
            end else begin
                m_ireq += int'(imem_req);
                m_ir   += int'(ir_load);
                m_dreq += int'(dmem_req);
                m_dwe  += int'(dmem_we);
                m_fst  += int'(fpu_start);
                m_rf   += int'(rf_we);
                if (pc_inc || pc_we_target) begin
                    if (sb.size() == 0) begin
                        check("unexpected_retire", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("retire_cycle", cyc, e.cyc);
                        check("pc_inc", pc_inc, e.inc);
                        check("pc_we_target", pc_we_target, e.tgt);
                        check("rf_we_count", m_rf, e.rf);
                        check("retired_before", retired, e.ret);
                        check("imem_req_cycles", m_ireq, e.n_ireq);
                        check("ir_load_count", m_ir, e.n_ir);
                        check("dmem_req_cycles", m_dreq, e.n_dreq);
                        check("dmem_we_cycles", m_dwe, e.n_dwe);
                        check("fpu_start_count", m_fst, e.n_fst);
                    end
                    m_ireq = 0; m_ir = 0; m_dreq = 0; m_dwe = 0; m_fst = 0; m_rf = 0;
                end
            end
        end
    end

    // Drive one instruction on a fixed timeline starting in a FETCH cycle.
    // which: 0 none, 1 dmem_ack, 2 fpu_done, raised dw cycles after entering MEM/FPU_WAIT.
    task automatic issue(input logic [4:0] op, input logic [11:0] lit, input logic tk,
                         input int di, input int which, input int dw, input int spur,
                         input int lat, input int inc, input int tgt, input int rf,
                         input int n_dreq, input int n_dwe, input int n_fst, input int retires);
        int   c0 = cyc;
        exp_t x;
        if (retires != 0) begin
            x.cyc = c0 + lat - 1; x.inc = inc; x.tgt = tgt; x.rf = rf; x.ret = exp_retired;
            x.n_ireq = di + 1; x.n_ir = 1; x.n_dreq = n_dreq; x.n_dwe = n_dwe; x.n_fst = n_fst;
            sb.push_back(x);
            exp_retired++;
        end
        opcode = op;
        literal = lit;
        branch_taken = tk;
        for (int k = 0; k < lat; k++) begin
            imem_ack = (k == di);
            dmem_ack = (which == 1) && (k == di + 3 + dw);
            fpu_done = ((which == 2) && (k == di + 3 + dw)) || ((spur != 0) && (k <= di));
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        fpu_done = 1'b0;
    endtask

    // One-cycle reset; returns 2 time units into the first FETCH cycle.
    task automatic do_reset();
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 0;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; literal = '0; branch_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; fpu_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        #1;
        check("fetch_after_reset", imem_req, 1);

        // ALU, load with late ack, store
        issue(5'h18, 12'd0, 1'b0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 1);
        check("retired_after_add", retired, 1);
        check("fetch_after_add", imem_req, 1);
        issue(5'h10, 12'd0, 1'b0, 0, 1, 3, 0, 8, 1, 0, 1, 4, 0, 0, 1);
        issue(5'h13, 12'd0, 1'b0, 0, 1, 0, 0, 4, 1, 0, 0, 1, 1, 0, 1);
        // branches taken/not taken, call, return
        issue(5'h0b, 12'd0, 1'b1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 1);
        issue(5'h0b, 12'd0, 1'b0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        issue(5'h0c, 12'd0, 1'b0, 1, 1, 1, 0, 6, 0, 1, 0, 2, 2, 0, 1);
        issue(5'h0d, 12'd0, 1'b0, 0, 1, 0, 0, 4, 0, 1, 0, 1, 0, 0, 1);
        // DIVF with done on the 10th wait cycle and spurious done during FETCH
        issue(5'h17, 12'd0, 1'b0, 1, 2, 9, 1, 15, 1, 0, 1, 0, 0, 1, 1);
        issue(5'h03, 12'd0, 1'b0, 2, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 1);
        check("retired_after_mix", retired, 9);

        // Halt is sticky, counted, and ignores acks
        issue(5'h0f, 12'd0, 1'b0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1);
        check("halted_set", halted, 1);
        check("halt_imem_req", imem_req, 0);
        check("halt_retired", retired, 10);
        imem_ack = 1'b1; dmem_ack = 1'b1; fpu_done = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("halted_sticky", halted, 1);
        check("halt_ir_load", ir_load, 0);
        check("halt_retired_frozen", retired, 10);
        imem_ack = 1'b0; dmem_ack = 1'b0; fpu_done = 1'b0;
        do_reset();
        check("halted_cleared", halted, 0);
        check("retired_cleared", retired, 0);

        // Illegal opcodes trap without retiring
        issue(5'h18, 12'd0, 1'b0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 1);
        issue(5'h1f, 12'd0, 1'b0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        check("illegal_set", illegal, 1);
        check("trap_retired", retired, 1);
        check("trap_not_halted", halted, 0);
        do_reset();
        check("illegal_cleared", illegal, 0);
        issue(5'h0f, 12'd3, 1'b0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        check("priv_lit_illegal", illegal, 1);
        check("priv_lit_not_halted", halted, 0);
        do_reset();

        // Fetch timeout: 64 waiting cycles then ERROR
        repeat (63) begin @(posedge clk); #1; end
        check("timeout_last_wait_error", error, 0);
        check("timeout_last_wait_req", imem_req, 1);
        @(posedge clk); #1;
        check("timeout_error", error, 1);
        check("timeout_req_dropped", imem_req, 0);
        do_reset();
        check("error_cleared", error, 0);
        // Ack on the 64th FETCH cycle still wins
        issue(5'h19, 12'd0, 1'b0, 63, 0, 0, 0, 67, 1, 0, 1, 0, 0, 0, 1);
        check("late_ack_no_error", error, 0);
        do_reset();

        // Reset mid-MEM aborts the data handshake
        opcode = 5'h10; literal = '0;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_mem_dmem_req", dmem_req, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("reset_gates_dmem_req", dmem_req, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 0;
        #1;
        check("after_reset_dmem_req", dmem_req, 0);
        check("after_reset_fetch", imem_req, 1);
        issue(5'h13, 12'd0, 1'b0, 0, 1, 0, 0, 4, 1, 0, 0, 1, 1, 0, 1);
        check("retired_after_abort", retired, 1);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
